// File: rtl/ibex_pkg.sv
// Shared types for the register-file dump/load controller.
package ibex_pkg;

    // Register-file address ports are always 5 bits; RV32E only narrows the counter.
    localparam int unsigned RF_ADDR_PORT_W = 5;

    typedef enum logic [1:0] {
        RF_DUMP_IDLE = 2'd0,
        RF_DUMP_DUMP = 2'd1,
        RF_DUMP_LOAD = 2'd2,
        RF_DUMP_DONE = 2'd3
    } rf_dump_state_e;

    typedef enum logic {
        RF_MODE_DUMP = 1'b0,
        RF_MODE_LOAD = 1'b1
    } rf_dump_mode_e;

    function automatic int unsigned rf_dump_num_words(input bit rv32e);
        return rv32e ? 32'd16 : 32'd32;
    endfunction

endpackage

// File: rtl/ibex_rf_dump_ctrl_if.sv
// Dump and load stream handshakes of the register-file dump controller.
interface ibex_rf_dump_ctrl_if
    import ibex_pkg::*;
#(
    parameter int DataWidth = 32
);
    logic                      dump_valid_o;
    logic                      dump_ready_i;
    logic [RF_ADDR_PORT_W-1:0] dump_addr_o;
    logic [DataWidth-1:0]      dump_data_o;
    logic                      load_valid_i;
    logic                      load_ready_o;
    logic [DataWidth-1:0]      load_data_i;

    // Controller side.
    modport master (
        output dump_valid_o, dump_addr_o, dump_data_o, load_ready_o,
        input  dump_ready_i, load_valid_i, load_data_i
    );

    // Stream consumer / producer side.
    modport slave (
        input  dump_valid_o, dump_addr_o, dump_data_o, load_ready_o,
        output dump_ready_i, load_valid_i, load_data_i
    );
endinterface

// File: rtl/ibex_rf_dump_ctrl.sv
// Streams the register file out (dump) or in (load), skipping x0.
module ibex_rf_dump_ctrl
    import ibex_pkg::*;
#(
    parameter bit RV32E     = 1'b0,
    parameter int DataWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic                      abort_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [RF_ADDR_PORT_W-1:0] rf_raddr_o,
    input  logic [DataWidth-1:0]      rf_rdata_i,
    output logic [RF_ADDR_PORT_W-1:0] rf_waddr_o,
    output logic [DataWidth-1:0]      rf_wdata_o,
    output logic                      rf_we_o,
    ibex_rf_dump_ctrl_if.master       stream
);

    localparam int unsigned NUM_WORDS  = rf_dump_num_words(RV32E);
    localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    rf_dump_state_e        state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    // Set once the last word is in the output register; the counter then
    // parks at LAST_ADDR instead of wrapping.
    logic                  last_cap_q;
    logic                  dump_valid_q;
    logic [ADDR_WIDTH-1:0] dump_addr_q;
    logic [DataWidth-1:0]  dump_data_q;
    logic                  done_q;

    logic dump_hs, dump_cap, load_hs;

    assign dump_hs  = dump_valid_q & stream.dump_ready_i;
    assign dump_cap = (state_q == RF_DUMP_DUMP) & (~dump_valid_q | stream.dump_ready_i) & ~last_cap_q;
    assign load_hs  = (state_q == RF_DUMP_LOAD) & stream.load_valid_i;

    // Combinational views derived from registered state.
    assign busy_o              = (state_q != RF_DUMP_IDLE);
    assign done_o              = done_q;
    assign rf_raddr_o          = (state_q == RF_DUMP_DUMP) ? RF_ADDR_PORT_W'(cnt_q) : '0;
    assign rf_waddr_o          = RF_ADDR_PORT_W'(cnt_q);
    assign rf_wdata_o          = stream.load_data_i;
    assign rf_we_o             = load_hs;
    assign stream.load_ready_o = (state_q == RF_DUMP_LOAD);
    assign stream.dump_valid_o = dump_valid_q;
    assign stream.dump_addr_o  = RF_ADDR_PORT_W'(dump_addr_q);
    assign stream.dump_data_o  = dump_data_q;

    // FSM, address counter and the one-entry dump output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RF_DUMP_IDLE;
            cnt_q        <= '0;
            last_cap_q   <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                RF_DUMP_IDLE: begin
                    if (start_i) begin
                        state_q    <= (rf_dump_mode_e'(mode_i) == RF_MODE_LOAD) ? RF_DUMP_LOAD
                                                                              : RF_DUMP_DUMP;
                        cnt_q      <= ADDR_WIDTH'(1);
                        last_cap_q <= 1'b0;
                    end
                end
                RF_DUMP_DUMP: begin
                    if (abort_i) begin
                        state_q      <= RF_DUMP_IDLE;
                        dump_valid_q <= 1'b0;
                    end else begin
                        if (dump_cap) begin
                            dump_data_q  <= rf_rdata_i;
                            dump_addr_q  <= cnt_q;
                            dump_valid_q <= 1'b1;
                            if (cnt_q == LAST_ADDR) begin
                                last_cap_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + ADDR_WIDTH'(1);
                            end
                        end else if (dump_hs) begin
                            dump_valid_q <= 1'b0;
                        end
                        // Word in the register is the last one once last_cap_q is set.
                        if (dump_hs && last_cap_q) begin
                            state_q <= RF_DUMP_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RF_DUMP_LOAD: begin
                    // The write itself is combinational, so it still lands on an abort cycle.
                    if (load_hs && cnt_q != LAST_ADDR) begin
                        cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    end
                    if (abort_i) begin
                        state_q <= RF_DUMP_IDLE;
                    end else if (load_hs && cnt_q == LAST_ADDR) begin
                        state_q <= RF_DUMP_DONE;
                        done_q  <= 1'b1;
                    end
                end
                RF_DUMP_DONE: begin
                    state_q <= RF_DUMP_IDLE;
                end
                default: state_q <= RF_DUMP_IDLE;
            endcase
        end
    end

endmodule
